hw_mutex_array: RTL

- Bank of NB_MUTEX independent hardware mutexes shared by NB_CORES cores, placed inside the event unit.
- Each channel tracks its owner, a pending-request mask and a message word passed from the releasing core to the next owner.
- Compared with the single-mutex unit it adds:
  - owner checking: illegal unlocks and re-locks are rejected and flagged;
  - per-channel errors;
  - optional round-robin fairness instead of fixed lowest-index priority.

---
 rtl/hw_mutex_pkg.sv | 19 +
 rtl/hw_mutex_channel.sv | 132 +++++++++++++
 rtl/hw_mutex_array.sv | 39 +++
 3 files changed

// File: rtl/hw_mutex_pkg.sv
// Shared types and helpers for the hardware mutex bank.
// Round-robin arbitration is enabled with `define HW_MUTEX_RR_EN.
package hw_mutex_pkg;

  typedef enum logic {
    MUTEX_FREE = 1'b0,
    MUTEX_HELD = 1'b1
  } mutex_state_e;

  localparam int unsigned NB_CORES_DEF    = 8;
  localparam int unsigned NB_MUTEX_DEF    = 4;
  localparam int unsigned MUTEX_MSG_W_DEF = 32;

  // Width of a core index; never zero so a 1-core build still has a legal vector.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hw_mutex_channel.sv
// One mutex channel: FREE/HELD FSM, owner, pending mask, message word,
// error flop and the grant arbiter (fixed lowest-index, or round-robin
// when HW_MUTEX_RR_EN is defined).
module hw_mutex_channel
  import hw_mutex_pkg::*;
#(
  parameter int unsigned NB_CORES    = NB_CORES_DEF,
  parameter int unsigned MUTEX_MSG_W = MUTEX_MSG_W_DEF
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NB_CORES-1:0]             lock_req_i,
  input  logic [NB_CORES-1:0]             unlock_req_i,
  input  logic [NB_CORES*MUTEX_MSG_W-1:0] msg_wdata_i,
  output logic [NB_CORES-1:0]             grant_o,
  output logic [MUTEX_MSG_W-1:0]          msg_o,
  output logic                            locked_o,
  output logic                            err_o
);

  localparam int unsigned IDX_W = idx_w(NB_CORES);

  mutex_state_e                             state_q, state_d;
  logic         [IDX_W-1:0]                 owner_q, owner_d;
  logic         [NB_CORES-1:0]              pend_q, pend_d;
  logic         [MUTEX_MSG_W-1:0]           msg_q, msg_d;
  logic                                     err_q, err_d;

  logic         [NB_CORES-1:0][MUTEX_MSG_W-1:0] wdata_arr;
  logic         [NB_CORES-1:0]              owner_oh, lock_f, elig, win_oh;
  logic         [IDX_W-1:0]                 win, ptr_nxt;
  logic                                     held, valid_unl, bad_unl, bad_lock, do_grant;

  assign wdata_arr = msg_wdata_i;

  // Lowest set bit of a core vector (returns 0 for an empty vector).
  function automatic logic [IDX_W-1:0] ff1(input logic [NB_CORES-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NB_CORES - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // Request filtering: only the owner may unlock, and an owner re-lock is
  // only meaningful when paired with its own unlock (it then re-queues).
  always_comb begin
    owner_oh  = NB_CORES'(1) << owner_q;
    held      = (state_q == MUTEX_HELD);
    valid_unl = held && |(unlock_req_i & owner_oh);
    bad_unl   = held ? |(unlock_req_i & ~owner_oh) : |unlock_req_i;
    bad_lock  = held && !valid_unl && |(lock_req_i & owner_oh);
    lock_f    = (held && !valid_unl) ? (lock_req_i & ~owner_oh) : lock_req_i;
    elig      = pend_q | lock_f;
    do_grant  = (!held || valid_unl) && |elig;
  end

`ifdef HW_MUTEX_RR_EN
  logic [IDX_W-1:0]      ptr_q;
  logic [2*NB_CORES-1:0] rot_dbl;
  logic [IDX_W:0]        sum;

  // Round-robin: rotate so the pointer position is bit 0, pick the first
  // set bit, then map back to a real core index.
  always_comb begin
    rot_dbl = {elig, elig} >> ptr_q;
    sum     = {1'b0, ff1(rot_dbl[NB_CORES-1:0])} + {1'b0, ptr_q};
    if (sum >= (IDX_W+1)'(NB_CORES)) sum = sum - (IDX_W+1)'(NB_CORES);
    win     = sum[IDX_W-1:0];
    ptr_nxt = (win == IDX_W'(NB_CORES - 1)) ? '0 : win + 1'b1;
  end

  // Pointer advances past the winner on every grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       ptr_q <= '0;
    else if (do_grant) ptr_q <= ptr_nxt;
  end
`else
  // Fixed priority: lowest eligible core index wins.
  always_comb begin
    win     = ff1(elig);
    ptr_nxt = '0;
  end
`endif

  assign win_oh = NB_CORES'(1) << win;

  // Next-state: queue waiters, release on owner unlock, grant/hand off.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    pend_d  = pend_q;
    msg_d   = msg_q;
    grant_o = '0;
    err_d   = bad_unl || bad_lock;
    if (held && !valid_unl) pend_d = pend_q | lock_f;
    if (valid_unl) begin
      msg_d   = wdata_arr[owner_q];
      state_d = MUTEX_FREE;
      pend_d  = '0;
    end
    if (do_grant) begin
      grant_o = win_oh;
      owner_d = win;
      pend_d  = elig & ~win_oh;
      state_d = MUTEX_HELD;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= MUTEX_FREE;
      owner_q <= '0;
      pend_q  <= '0;
      msg_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      pend_q  <= pend_d;
      msg_q   <= msg_d;
      err_q   <= err_d;
    end
  end

  assign msg_o    = msg_q;
  assign locked_o = (state_q == MUTEX_HELD);
  assign err_o    = err_q;

endmodule

// File: rtl/hw_mutex_array.sv
// Bank of NB_MUTEX independent hardware mutexes shared by NB_CORES cores.
// Define HW_MUTEX_RR_EN for round-robin fairness instead of fixed priority.
module hw_mutex_array
  import hw_mutex_pkg::*;
#(
  parameter int unsigned NB_CORES    = NB_CORES_DEF,
  parameter int unsigned NB_MUTEX    = NB_MUTEX_DEF,
  parameter int unsigned MUTEX_MSG_W = MUTEX_MSG_W_DEF
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NB_MUTEX*NB_CORES-1:0]    lock_req_i,
  input  logic [NB_MUTEX*NB_CORES-1:0]    unlock_req_i,
  input  logic [NB_CORES*MUTEX_MSG_W-1:0] mutex_msg_wdata_i,
  output logic [NB_MUTEX*MUTEX_MSG_W-1:0] mutex_msg_rdata_o,
  output logic [NB_MUTEX*NB_CORES-1:0]    mutex_event_o,
  output logic [NB_MUTEX-1:0]             mutex_locked_o,
  output logic [NB_MUTEX-1:0]             mutex_err_o
);

  // One channel per mutex; each sees the full write-data bus.
  for (genvar m = 0; m < NB_MUTEX; m++) begin : g_ch
    hw_mutex_channel #(
      .NB_CORES   (NB_CORES),
      .MUTEX_MSG_W(MUTEX_MSG_W)
    ) u_ch (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .lock_req_i  (lock_req_i[m*NB_CORES +: NB_CORES]),
      .unlock_req_i(unlock_req_i[m*NB_CORES +: NB_CORES]),
      .msg_wdata_i (mutex_msg_wdata_i),
      .grant_o     (mutex_event_o[m*NB_CORES +: NB_CORES]),
      .msg_o       (mutex_msg_rdata_o[m*MUTEX_MSG_W +: MUTEX_MSG_W]),
      .locked_o    (mutex_locked_o[m]),
      .err_o       (mutex_err_o[m])
    );
  end

endmodule
